// File: rtl/coreport_ext.sv
// Wishbone classic GPIO port: synchronised inputs, atomic SET/CLR/TGL writes,
// per-pin level/edge interrupts with polarity, W1C flags, one-wait-state ack.
module coreport_ext #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] INITIAL_DDR   = '0,
    parameter logic [WIDTH-1:0] INITIAL_DATAR = '0,
    parameter int               SYNC_STAGES   = 2
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic [2:0]       wb_cti_i,
    input  logic [1:0]       wb_bte_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] datar, ddr, imr, ifr, ier, ipr, dir;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in, prev;
    logic [WIDTH-1:0] wdat, rdat, evt, w1c;
    logic [31:0]      rdat_ext;
    logic [7:0]       adr;
    logic             req, wr;
    logic             unused_bits;

    assign adr     = wb_adr_i[7:0];
    assign wdat    = wb_dat_i[WIDTH-1:0];
    assign sync_in = sync_q[SYNC_STAGES-1];
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = req & wb_we_i;

    assign gpio_o   = datar;
    assign gpio_oe  = ddr & ~{WIDTH{wb_rst}};
    assign irq      = |(ifr & imr);
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    assign unused_bits = &{1'b0, wb_cti_i, wb_bte_i, wb_adr_i[31:8], wb_dat_i};

    always_comb begin
        rdat = '0;
        case (adr)
            8'h00:   rdat = sync_in ^ dir;
            8'h04:   rdat = ddr;
            8'h08:   rdat = imr;
            8'h0C:   rdat = ifr;
            8'h10:   rdat = ier;
            8'h14:   rdat = ipr;
            8'h18:   rdat = dir;
            default: rdat = '0;
        endcase
        rdat_ext             = '0;
        rdat_ext[WIDTH-1:0]  = rdat;
    end

    // Level mode fires while sync_in matches ~IPR, i.e. sync_in ^ IPR.
    always_comb begin
        evt = ~ddr & ((ier & ((~ipr & ~prev & sync_in) | (ipr & prev & ~sync_in)))
                    | (~ier & (sync_in ^ ipr)));
        w1c = (wr && adr == 8'h0C) ? wdat : '0;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            datar    <= INITIAL_DATAR;
            ddr      <= INITIAL_DDR;
            imr      <= '0;
            ifr      <= '0;
            ier      <= '0;
            ipr      <= '0;
            dir      <= '0;
            prev     <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev     <= sync_in;
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rdat_ext : '0;
            // A new event wins over a same-cycle clear.
            ifr      <= (ifr & ~w1c) | evt;
            if (wr) begin
                case (adr)
                    8'h00:   datar <= wdat ^ dir;
                    8'h04:   ddr   <= wdat;
                    8'h08:   imr   <= wdat;
                    8'h10:   ier   <= wdat;
                    8'h14:   ipr   <= wdat;
                    8'h18:   dir   <= wdat;
                    8'h1C:   datar <= datar | wdat;
                    8'h20:   datar <= datar & ~wdat;
                    8'h24:   datar <= datar ^ wdat;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coreport_ext.sv
// Bench for coreport_ext: directed scenarios plus random traffic, all checked
// every cycle against a register-level model of the port.
module tb_coreport_ext;
    localparam int W = 8;
    localparam int S = 2;

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b1;
    logic [31:0]   wb_adr_i = '0, wb_dat_i = '0;
    logic          wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
    logic [2:0]    wb_cti_i = '0;
    logic [1:0]    wb_bte_i = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o, wb_err_o, wb_rty_o;
    logic [W-1:0]  gpio_i = '0;
    logic [W-1:0]  gpio_o, gpio_oe;
    logic          irq;

    int vectors = 0;
    int miscompares = 0;

    always #5 wb_clk = ~wb_clk;

    coreport_ext #(.WIDTH(W), .INITIAL_DDR(8'hF0), .INITIAL_DATAR(8'hA5), .SYNC_STAGES(S)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i),
        .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_rty_o(wb_rty_o), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_datar, m_ddr, m_imr, m_ifr, m_ier, m_ipr, m_dir;
    logic         m_ack = 1'b0, m_rd_valid = 1'b0, live = 1'b0;
    logic [31:0]  m_rdat = '0;
    logic [W-1:0] hist[$];   // hist[0] = newest gpio_i sample
    logic [W-1:0] s, p, ev, rv, w1c;
    logic         req;

    function automatic logic [W-1:0] reg_read(input logic [7:0] a, input logic [W-1:0] sy);
        case (a)
            8'h00: return sy ^ m_dir;
            8'h04: return m_ddr;
            8'h08: return m_imr;
            8'h0C: return m_ifr;
            8'h10: return m_ier;
            8'h14: return m_ipr;
            8'h18: return m_dir;
            default: return '0;
        endcase
    endfunction

    always @(posedge wb_clk) begin
        if (wb_rst) begin
            m_datar = 8'hA5; m_ddr = 8'hF0;
            m_imr = '0; m_ifr = '0; m_ier = '0; m_ipr = '0; m_dir = '0;
            hist = {};
            for (int i = 0; i <= S; i++) hist.push_back('0);
            m_ack = 1'b0; m_rd_valid = 1'b0; m_rdat = '0;
            live = 1'b1;
        end else if (live) begin
            s = hist[S-1];
            p = hist[S];
            for (int i = 0; i < W; i++) begin
                if (m_ddr[i])       ev[i] = 1'b0;
                else if (m_ier[i])  ev[i] = m_ipr[i] ? (p[i] && !s[i]) : (!p[i] && s[i]);
                else                ev[i] = (s[i] == !m_ipr[i]);
            end
            req = wb_cyc_i && wb_stb_i && !m_ack;
            w1c = '0;
            rv  = '0;
            if (req) begin
                rv = reg_read(wb_adr_i[7:0], s);
                if (wb_we_i) begin
                    case (wb_adr_i[7:0])
                        8'h00: m_datar = wb_dat_i[W-1:0] ^ m_dir;
                        8'h04: m_ddr = wb_dat_i[W-1:0];
                        8'h08: m_imr = wb_dat_i[W-1:0];
                        8'h0C: w1c   = wb_dat_i[W-1:0];
                        8'h10: m_ier = wb_dat_i[W-1:0];
                        8'h14: m_ipr = wb_dat_i[W-1:0];
                        8'h18: m_dir = wb_dat_i[W-1:0];
                        8'h1C: m_datar = m_datar | wb_dat_i[W-1:0];
                        8'h20: m_datar = m_datar & ~wb_dat_i[W-1:0];
                        8'h24: m_datar = m_datar ^ wb_dat_i[W-1:0];
                        default: ;
                    endcase
                end
            end
            m_ifr      = (m_ifr & ~w1c) | ev;
            m_ack      = req;
            m_rd_valid = req && !wb_we_i;
            m_rdat     = {24'h0, rv};
            hist.push_front(gpio_i);
            void'(hist.pop_back());
        end
    end

    // Compare process: every cycle once the first reset edge has happened.
    always @(posedge wb_clk) begin
        #1;
        if (live) begin
            chk("gpio_o", {24'h0, gpio_o}, {24'h0, m_datar});
            chk("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_ddr & ~{W{wb_rst}}});
            chk("irq", {31'h0, irq}, {31'h0, |(m_ifr & m_imr)});
            chk("ack", {31'h0, wb_ack_o}, {31'h0, m_ack});
            chk("err_rty", {30'h0, wb_err_o, wb_rty_o}, 32'h0);
            if (m_rd_valid) chk("dat_o", wb_dat_o, m_rdat);
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       output logic [31:0] rd);
        @(negedge wb_clk);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge wb_clk);
            if (wb_ack_o) break;
        end
        chk("ack_seen", {31'h0, wb_ack_o}, 32'h1);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] junk;
        bus({24'h0, a}, 1'b1, d, junk);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus({24'h0, a}, 1'b0, 32'h0, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end

    logic [31:0] d;
    logic [7:0]  addrs [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                8'h1C, 8'h20, 8'h24, 8'h40, 8'h02};

    initial begin
        // 1: reset values
        repeat (2) @(posedge wb_clk);
        #1 chk("oe_in_reset", {24'h0, gpio_oe}, 32'h0);
        chk("gpio_o_reset", {24'h0, gpio_o}, 32'hA5);
        @(negedge wb_clk) wb_rst = 1'b0;
        @(posedge wb_clk) #1 chk("oe_after_reset", {24'h0, gpio_oe}, 32'hF0);
        chk("ack_idle", {31'h0, wb_ack_o}, 32'h0);
        rd(8'h04, d); chk("rd_ddr", d, 32'hF0);
        rd(8'h00, d); chk("rd_datar", d, 32'h0);

        // 2: atomic ops and inversion
        wr(8'h00, 32'h0F); wr(8'h1C, 32'h30); wr(8'h20, 32'h01); wr(8'h24, 32'hFF);
        chk("atomic_result", {24'h0, gpio_o}, 32'hC1);
        wr(8'h18, 32'hFF); gpio_i = '0; idle(3);
        rd(8'h00, d); chk("rd_inverted", d, 32'hFF);
        wr(8'h18, 32'h00);

        // 3: rising edge on bit 0, latency and W1C
        wr(8'h10, 32'h01); wr(8'h14, 32'h00); wr(8'h08, 32'h01); wr(8'h0C, 32'hFF);
        @(negedge wb_clk) gpio_i[0] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge wb_clk) #1;
            chk($sformatf("irq_edge%0d", e), {31'h0, irq}, (e == 3) ? 32'h1 : 32'h0);
        end
        rd(8'h0C, d); chk("ifr_rise", d, 32'h01);
        wr(8'h0C, 32'h01); chk("irq_cleared", {31'h0, irq}, 32'h0);
        idle(5);
        rd(8'h0C, d); chk("ifr_no_refire", d, 32'h00);

        // 4: level-low on bit 2 re-asserts through W1C
        wr(8'h10, 32'h00); wr(8'h14, 32'h04);
        wr(8'h0C, 32'h04); rd(8'h0C, d); chk("level_persist", d & 32'h04, 32'h04);
        @(negedge wb_clk) gpio_i[2] = 1'b1;
        idle(4);
        wr(8'h0C, 32'h04); rd(8'h0C, d); chk("level_released", d & 32'h04, 32'h00);

        // 5: output pins never flag; undecoded read
        wr(8'h04, 32'h01); wr(8'h10, 32'h01); wr(8'h0C, 32'hFF);
        for (int t = 0; t < 6; t++) begin
            @(negedge wb_clk) gpio_i[0] = ~gpio_i[0];
            idle(3);
        end
        rd(8'h0C, d); chk("output_pin_no_flag", d, 32'h00);
        rd(8'h40, d); chk("undecoded_read", d, 32'h00);

        // 6: reset aborts an in-flight IMR write
        wr(8'h08, 32'hFF);
        @(negedge wb_clk);
        wb_adr_i = 32'h08; wb_dat_i = 32'h5A; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_rst = 1'b1;
        @(posedge wb_clk) #1;
        chk("abort_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("abort_irq", {31'h0, irq}, 32'h0);
        @(negedge wb_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_rst = 1'b0;
        rd(8'h08, d); chk("abort_imr", d, 32'h00);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin @(negedge wb_clk); gpio_i = W'($urandom); end
                3, 4, 5: wr(addrs[$urandom_range(0, 11)], $urandom);
                6, 7:    rd(addrs[$urandom_range(0, 11)], d);
                8:       idle($urandom_range(1, 3));
                default: begin
                    @(negedge wb_clk);
                    if ($urandom_range(0, 9) == 0) begin
                        wb_rst = 1'b1;
                        @(negedge wb_clk) wb_rst = 1'b0;
                    end else begin
                        gpio_i[$urandom_range(0, W-1)] ^= 1'b1;
                    end
                end
            endcase
        end
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
